// File: rtl/ifid_hazard_if.sv
// IF/ID hazard controller bundle: ID/EX hazard inputs, pipeline enables and hold values, status.
// The controller takes the slave side; the pipeline datapath takes the master side.
interface ifid_hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       IDRs;
    logic [4:0]       IDRt;
    logic             IDUsesRt;
    logic             IDMultiStart;
    logic             IDEXMemRead;
    logic [4:0]       IDEXRt;
    logic             BranchTaken;
    logic [31:0]      IFIDPC;
    logic [31:0]      IFIDInstr;

    logic             PCWrite;
    logic             IFIDWrite;
    logic             PCSrc3;
    logic             IDEXBubble;
    logic [31:0]      pcback;
    logic [31:0]      instructionback;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output IDRs, IDRt, IDUsesRt, IDMultiStart, IDEXMemRead, IDEXRt,
               BranchTaken, IFIDPC, IFIDInstr,
        input  PCWrite, IFIDWrite, PCSrc3, IDEXBubble, pcback, instructionback,
               Busy, StallCount, FlushCount
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, IDMultiStart, IDEXMemRead, IDEXRt,
               BranchTaken, IFIDPC, IFIDInstr,
        output PCWrite, IFIDWrite, PCSrc3, IDEXBubble, pcback, instructionback,
               Busy, StallCount, FlushCount
    );
endinterface

// File: rtl/ifid_hazard_controller.sv
// IF/ID + PC sequencing: load-use stall, multi-cycle-op occupancy, taken-branch flush; control is same-cycle combinational.
// Stalls hold PC and IF/ID by re-latching their current contents; stall/flush statistics saturate.
module ifid_hazard_controller #(
    parameter int unsigned MULTI_CYCLES = 4,   // total EX occupancy of a multi-cycle op, 1..15
    parameter int unsigned CNT_W        = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    ifid_hazard_if.slave  hz
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

    localparam logic [3:0]       MC_INIT = 4'(MULTI_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic loaduse;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    // Register 0 is hardwired, so a load targeting it never blocks a consumer.
    assign loaduse = hz.IDEXMemRead
                   && (hz.IDEXRt != 5'd0)
                   && ((hz.IDEXRt == hz.IDRs) || (hz.IDUsesRt && (hz.IDEXRt == hz.IDRt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (hz.BranchTaken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (loaduse) begin
                    // A mul held here stays in ID and issues once the load clears.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (hz.IDMultiStart && (MULTI_CYCLES > 1)) begin
                    state_d = ST_MULTI;
                    cnt_d   = MC_INIT;
                end
            end
            ST_MULTI: begin
                if (hz.BranchTaken) begin
                    // The branch is older than the op in EX, so it kills the op.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                    cnt_d       = 4'd0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase

        if (Reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
        if (ifid_flush && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.PCWrite         = pc_write;
    assign hz.IFIDWrite       = ifid_write;
    assign hz.PCSrc3          = ifid_flush;
    assign hz.IDEXBubble      = idex_bubble;
    assign hz.pcback          = hz.IFIDPC;
    assign hz.instructionback = hz.IFIDInstr;
    assign hz.Busy            = (state_q == ST_MULTI) && !Reset;
    assign hz.StallCount      = stall_q;
    assign hz.FlushCount      = flush_q;

endmodule

// File: tb/tb_ifid_hazard_controller.sv
// Directed then random stimulus against a cycle-level reference model of the hazard rules.
module tb_ifid_hazard_controller;

    localparam int MC   = 4;
    localparam int CW   = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    ifid_hazard_if #(.CNT_W(CW)) hif ();

    ifid_hazard_controller #(.MULTI_CYCLES(MC), .CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hif.slave)
    );

    int checks = 0;
    int passes = 0;
    // Model: stall cycles still owed to an op in EX, plus statistics.
    int mul_left = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic step(string tag, bit rst, bit br, bit mr, logic [4:0] exrt,
                        logic [4:0] rs, logic [4:0] rt, bit uses, bit ms);
        bit lu;
        bit [4:0] e;   // {PCWrite, IFIDWrite, PCSrc3, IDEXBubble, Busy}
        logic [31:0] pc, ins;
        @(negedge Clk);
        pc  = $urandom;
        ins = $urandom;
        Reset            = rst;
        hif.BranchTaken  = br;
        hif.IDEXMemRead  = mr;
        hif.IDEXRt       = exrt;
        hif.IDRs         = rs;
        hif.IDRt         = rt;
        hif.IDUsesRt     = uses;
        hif.IDMultiStart = ms;
        hif.IFIDPC       = pc;
        hif.IFIDInstr    = ins;
        #1;
        lu = mr && (exrt != 0) && ((exrt == rs) || (uses && (exrt == rt)));
        if (rst)               e = 5'b11110;
        else if (br)           e = {4'b1111, mul_left > 0};
        else if (mul_left > 0) e = 5'b00011;
        else if (lu)           e = 5'b00010;
        else                   e = 5'b11000;
        chk1({tag, ".PCWrite"},    hif.PCWrite,    e[4]);
        chk1({tag, ".IFIDWrite"},  hif.IFIDWrite,  e[3]);
        chk1({tag, ".PCSrc3"},     hif.PCSrc3,     e[2]);
        chk1({tag, ".IDEXBubble"}, hif.IDEXBubble, e[1]);
        chk1({tag, ".Busy"},       hif.Busy,       e[0]);
        chk({tag, ".pcback"},          hif.pcback,          pc);
        chk({tag, ".instructionback"}, hif.instructionback, ins);
        if (!rst) begin
            chk({tag, ".StallCount"}, {{(32-CW){1'b0}}, hif.StallCount}, m_stalls);
            chk({tag, ".FlushCount"}, {{(32-CW){1'b0}}, hif.FlushCount}, m_flushes);
        end
        @(posedge Clk);
        if (rst) begin
            mul_left  = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (!e[4] && m_stalls < MAXC) m_stalls++;
            if (e[2] && m_flushes < MAXC) m_flushes++;
            if (br)                mul_left = 0;
            else if (mul_left > 0) mul_left--;
            else if (!lu && ms)    mul_left = MC - 1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        hif.BranchTaken = 0; hif.IDEXMemRead = 0; hif.IDEXRt = 0; hif.IDRs = 0;
        hif.IDRt = 0; hif.IDUsesRt = 0; hif.IDMultiStart = 0; hif.IFIDPC = 0; hif.IFIDInstr = 0;

        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        step("lu_rs",      0, 0, 1, 8, 8, 3, 0, 0);
        step("after_lu",   0, 0, 0, 8, 8, 3, 0, 0);
        step("lu_r0",      0, 0, 1, 0, 0, 0, 1, 0);
        step("rt_nouse",   0, 0, 1, 9, 4, 9, 0, 0);
        step("rt_use",     0, 0, 1, 9, 4, 9, 1, 0);
        step("after_rt",   0, 0, 0, 9, 4, 9, 1, 0);

        step("mul_issue",  0, 0, 0, 0, 1, 2, 1, 1);
        repeat (3) step("mul_busy", 0, 0, 0, 0, 1, 2, 1, 0);
        step("mul_done",   0, 0, 0, 0, 1, 2, 1, 0);

        step("lu_defer",   0, 0, 1, 5, 5, 0, 0, 1);
        step("mul_late",   0, 0, 0, 5, 5, 0, 0, 1);
        step("multi_1st",  0, 0, 0, 0, 0, 0, 0, 0);
        step("br_multi",   0, 1, 0, 0, 0, 0, 0, 0);
        step("after_br",   0, 0, 0, 0, 0, 0, 0, 0);

        step("br_lu_mul",  0, 1, 1, 7, 7, 7, 1, 1);
        step("after_all",  0, 0, 0, 0, 0, 0, 0, 0);

        step("mul_issue2", 0, 0, 0, 0, 0, 0, 0, 1);
        step("multi_a",    0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_multi",  1, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst",   0, 0, 0, 0, 0, 0, 0, 0);

        // Long random phase without reset drives the narrow counters into saturation.
        for (int i = 0; i < 700; i++) begin
            step("rand",
                 (i > 400) && ($urandom_range(0, 149) == 0),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0);
        end
        step("final_rst",  1, 0, 0, 0, 0, 0, 0, 0);
        step("final_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
